alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//   Shares one instance of the team's parameterised ALU among NUM_REQ requesters.
//   Arbitration is round-robin; each accepted command runs through a 3-state FSM.
//   The registered result and flags return to the winner over a valid/ready response channel.
//   Sits between requester blocks (sequencers, DMA address units) and the ALU datapath.
// PARAMETERS
//   WIDTH    8   operand/result width; passed unchanged to the ALU instance
//   NUM_REQ  4   number of requesters, >=2
//   CNT_W    16  width of completed-operation counter
//   (localparam ID_W = max(1, $clog2(NUM_REQ)))
// PORTS
//   clk        in   1              single clock, all state on rising edge
//   rst        in   1              synchronous reset, active-high
//   req_valid  in   NUM_REQ        per-requester command valid
//   req_ready  out  NUM_REQ        per-requester accept; at most one bit high
//   req_op     in   3*NUM_REQ      ALU opcodes, requester i at [3i+:3]; ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7
//   req_a      in   WIDTH*NUM_REQ  operand a, requester i at [WIDTH*i+:WIDTH]
//   req_b      in   WIDTH*NUM_REQ  operand b / shift amount, same packing
//   rsp_valid  out  1              response valid
//   rsp_ready  in   1              response accept
//   rsp_id     out  ID_W           index of requester owning the response
//   rsp_y      out  WIDTH          ALU result
//   rsp_flags  out  4              {overflow, carry, zero, negative}
//   busy       out  1              high whenever state != IDLE
//   op_count   out  CNT_W          responses completed since reset, wraps
// BEHAVIOUR
//   Reset: state=IDLE, rr_last=NUM_REQ-1 (req 0 highest priority first), rsp_valid=0,
//     rsp_id/rsp_y/rsp_flags=0, op_count=0, busy=0. req_ready is 0 during the rst cycle.
//   Arbiter: combinational. Scan from rr_last+1 upward, modulo NUM_REQ; the first valid wins.
//     req_ready[i] = (state==IDLE) && grant[i] && !rst.
//   Handshake: a transfer occurs when req_valid[i] && req_ready[i].
//     The requester holds op/a/b stable while valid and not ready.
//     Dropping valid before grant is legal and cancels nothing.
//   FSM:
//     IDLE: on any transfer, latch op/a/b/id into operand regs, set rr_last=id, go to EXEC.
//       With no requests, stay in IDLE.
//     EXEC: the ALU sees only the latched operands. Capture y and flags into rsp regs,
//       assert rsp_valid, go to RESP. Always exactly 1 cycle.
//     RESP: hold rsp_* stable while !rsp_ready. On rsp_ready: rsp_valid=0, op_count+=1
//       (wraps 2^CNT_W-1 -> 0), go to IDLE.
//   Latency: transfer on edge N -> rsp_valid high from edge N+2.
//     Minimum issue interval is 3 cycles; IDLE is never bypassed.
//   No new req_ready while in EXEC or RESP; an unbounded rsp_ready stall blocks all requesters.
//   Arithmetic and flags are exactly the ALU's:
//     carry = bit WIDTH of the (WIDTH+1)-bit add/sub (borrow on SUB); overflow on signed ADD/SUB only.
//     Shifts saturate at WIDTH; zero = (y==0); negative = y[WIDTH-1]; logic/shift ops give overflow=carry=0.
//   Reset mid-operation (EXEC or RESP): the command is discarded with no response,
//     op_count is not incremented, all outputs return to reset values on the next edge.
// TESTING (WIDTH=8, NUM_REQ=4)
//   1. Req1 ADD a=0x7F b=0x01 -> ready[1] same cycle; 2 cycles later rsp_id=1 y=0x80 flags=4'b1001; op_count=1.
//   2. Req0 SUB a=0x00 b=0x01 and req2 SRA a=0x80 b=0x09 valid together after reset ->
//      req0 first (y=0xFF flags=4'b0101), then req2 (y=0xFF flags=4'b0001); with req0 re-asserted, req2 still precedes it.
//   3. rsp_ready low 5 cycles during RESP -> rsp_y/rsp_id/rsp_flags constant, rsp_valid high, req_ready all 0, busy=1.
//   4. All four requesters valid continuously for 12 responses -> grant order 0,1,2,3,0,1,...;
//      each response arrives exactly 3 cycles after the previous.
//   5. rst asserted in EXEC, then in RESP -> next cycle rsp_valid=0, busy=0, op_count unchanged, no response for that command.
//   6. Preload op_count=0xFFFF via 65535 XOR ops (or force) -> one more response gives op_count=0x0000.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one ALU among NUM_REQ requesters.
// The result and flags are held in registers until the winning requester accepts them.

module rr_alu #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic [3:0]       o_flags
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;
  logic           w_sat;
  logic           w_ovf;
  logic           w_carry;

  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};
  // Shift amounts of WIDTH or more saturate instead of wrapping.
  assign w_sat = (i_b >= SH_LIM);

  always_comb begin
    o_y     = '0;
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y     = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_y     = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_SLL: o_y = w_sat ? '0 : (i_a << i_b);
      OP_SRL: o_y = w_sat ? '0 : (i_a >> i_b);
      OP_SRA: o_y = w_sat ? {WIDTH{i_a[WIDTH-1]}} : $unsigned($signed(i_a) >>> i_b);
      default: o_y = '0;
    endcase
  end

  assign o_flags = {w_ovf, w_carry, (o_y == '0), o_y[WIDTH-1]};

endmodule

// state | meaning
// IDLE  | arbitrate; accept one command and latch its operands
// EXEC  | ALU runs on latched operands; capture result into response regs
// RESP  | hold response until i_rsp_ready, then count and return to IDLE
module alu_rr_scheduler #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [3*NUM_REQ-1:0]     i_req_op,
  input  logic [WIDTH*NUM_REQ-1:0] i_req_a,
  input  logic [WIDTH*NUM_REQ-1:0] i_req_b,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [WIDTH-1:0]         o_rsp_y,
  output logic [3:0]               o_rsp_flags,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_rr_last;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [ID_W-1:0]  r_id;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_y;
  logic [3:0]       r_rsp_flags;
  logic [CNT_W-1:0] r_op_count;

  logic [2:0]         w_op_arr [NUM_REQ];
  logic [WIDTH-1:0]   w_a_arr  [NUM_REQ];
  logic [WIDTH-1:0]   w_b_arr  [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_sel;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_alu_y;
  logic [3:0]         w_alu_flags;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op_arr[g] = i_req_op[3*g +: 3];
    assign w_a_arr[g]  = i_req_a[WIDTH*g +: WIDTH];
    assign w_b_arr[g]  = i_req_b[WIDTH*g +: WIDTH];
  end

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_any   = 1'b0;
    w_sel   = '0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_rr_last) + i) % NUM_REQ);
      if (!w_any && i_req_valid[w_idx]) begin
        w_any          = 1'b1;
        w_sel          = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign o_req_ready = ((r_state == S_IDLE) && !i_rst) ? w_grant : '0;
  assign w_xfer      = |(i_req_valid & o_req_ready);

  rr_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op    (r_op),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_y     (w_alu_y),
    .o_flags (w_alu_flags)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rr_last   <= ID_W'(NUM_REQ - 1);
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_rsp_flags <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_op      <= w_op_arr[w_sel];
            r_a       <= w_a_arr[w_sel];
            r_b       <= w_b_arr[w_sel];
            r_id      <= w_sel;
            r_rr_last <= w_sel;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_y     <= w_alu_y;
          r_rsp_flags <= w_alu_flags;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_y     = r_rsp_y;
  assign o_rsp_flags = r_rsp_flags;
  assign o_busy      = (r_state != S_IDLE);
  assign o_op_count  = r_op_count;

endmodule
